// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline stage with a two-entry skid buffer and synchronous flush
module pipe_stage_reg #(
  parameter int CTRL_W  = 11,
  parameter int DATA_W  = 32,
  parameter int NUM_OPS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CTRL_W-1:0]         in_ctrl,
  input  logic [NUM_OPS*DATA_W-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CTRL_W-1:0]         out_ctrl,
  output logic [NUM_OPS*DATA_W-1:0] out_data,
  output logic [1:0]                occupancy
);
  localparam int W = NUM_OPS * DATA_W;
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
  state_t state_q, state_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d, skid_ctrl_q, skid_ctrl_d;
  logic [W-1:0] main_data_q, main_data_d, skid_data_q, skid_data_d;
  logic accept, deliver;
  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;
  // State register: entry count, cleared immediately by reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= EMPTY;
    else state_q <= state_d;
  end
  // Next state: flush wins; TWO only drains; otherwise accept/deliver move the count
  always_comb begin
    state_d = state_q;
    if (flush) state_d = EMPTY;
    else if (state_q == TWO) state_d = deliver ? ONE : TWO;
    else if (accept) state_d = (state_q == EMPTY || deliver) ? ONE : TWO;
    else if (deliver) state_d = EMPTY;
  end
  // Entry contents: new input lands in main when main frees up, otherwise in skid; drained main ctrl becomes a bubble
  always_comb begin
    main_ctrl_d = main_ctrl_q;
    main_data_d = main_data_q;
    skid_ctrl_d = skid_ctrl_q;
    skid_data_d = skid_data_q;
    if (flush) begin
      main_ctrl_d = '0;
      main_data_d = '0;
      skid_ctrl_d = '0;
      skid_data_d = '0;
    end else if (state_q == TWO) begin
      main_ctrl_d = deliver ? skid_ctrl_q : main_ctrl_q;
      main_data_d = deliver ? skid_data_q : main_data_q;
    end else if (accept && (state_q == EMPTY || deliver)) begin
      main_ctrl_d = in_ctrl;
      main_data_d = in_data;
    end else if (accept) begin
      skid_ctrl_d = in_ctrl;
      skid_data_d = in_data;
    end else if (deliver) begin
      main_ctrl_d = '0;
    end
  end
  // Entry registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      main_ctrl_q <= '0;
      main_data_q <= '0;
      skid_ctrl_q <= '0;
      skid_data_q <= '0;
    end else begin
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
      skid_ctrl_q <= skid_ctrl_d;
      skid_data_q <= skid_data_d;
    end
  end
  // Outputs decoded from registered state only, so no in_valid/out_ready combinational paths
  always_comb begin
    in_ready  = state_q != TWO;
    out_valid = state_q != EMPTY;
    occupancy = state_q;
    out_ctrl  = main_ctrl_q;
    out_data  = main_data_q;
  end
endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: directed checks of handshake, skid, flush, reset and parameter sweep
module tb_pipe_stage_reg;
  logic clk, reset;
  logic flush, in_valid, in_ready, out_valid, out_ready;
  logic [10:0] in_ctrl, out_ctrl;
  logic [63:0] in_data, out_data;
  logic [1:0] occupancy;
  logic p_flush, p_in_valid, p_in_ready, p_out_valid, p_out_ready;
  logic [4:0] p_in_ctrl, p_out_ctrl;
  logic [23:0] p_in_data, p_out_data;
  logic [1:0] p_occupancy;
  int checks = 0;
  int errors = 0;

  pipe_stage_reg dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .occupancy(occupancy)
  );

  pipe_stage_reg #(.CTRL_W(5), .DATA_W(8), .NUM_OPS(3)) dut_p (
    .clk(clk), .reset(reset), .flush(p_flush), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .in_ctrl(p_in_ctrl), .in_data(p_in_data), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .out_ctrl(p_out_ctrl), .out_data(p_out_data), .occupancy(p_occupancy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [10:0] c, input logic [63:0] d);
    in_valid = 1'b1;
    in_ctrl  = c;
    in_data  = d;
  endtask

  initial begin
    reset = 1'b1;
    flush = 1'b0; in_valid = 1'b0; in_ctrl = '0; in_data = '0; out_ready = 1'b0;
    p_flush = 1'b0; p_in_valid = 1'b0; p_in_ctrl = '0; p_in_data = '0; p_out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_occ", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_ctrl", 64'(out_ctrl), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_p_occ", 64'(p_occupancy), 64'd0);
    reset = 1'b0;

    out_ready = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      send(11'(k), {32'(100 + k), 32'(k)});
      @(negedge clk);
      chk("stream_ctrl", 64'(out_ctrl), 64'(k));
      chk("stream_data", out_data, {32'(100 + k), 32'(k)});
      chk("stream_valid", 64'(out_valid), 64'd1);
      chk("stream_occ", 64'(occupancy), 64'd1);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
    end
    in_valid = 1'b0;
    @(negedge clk);
    chk("bubble_valid", 64'(out_valid), 64'd0);
    chk("bubble_ctrl", 64'(out_ctrl), 64'd0);
    chk("bubble_data_hold", out_data, {32'd108, 32'd8});
    chk("bubble_occ", 64'(occupancy), 64'd0);

    out_ready = 1'b0;
    send(11'h0A1, {32'hA2, 32'hA1});
    @(negedge clk);
    chk("bp_occ1", 64'(occupancy), 64'd1);
    chk("bp_ctrl_a", 64'(out_ctrl), 64'h0A1);
    send(11'h0B1, {32'hB2, 32'hB1});
    @(negedge clk);
    chk("bp_occ2", 64'(occupancy), 64'd2);
    chk("bp_in_ready0", 64'(in_ready), 64'd0);
    chk("bp_ctrl_a_held", 64'(out_ctrl), 64'h0A1);
    chk("bp_data_a_held", out_data, {32'hA2, 32'hA1});
    send(11'h0F1, {32'hF2, 32'hF1});
    @(negedge clk);
    chk("bp_two_hold_occ", 64'(occupancy), 64'd2);
    chk("bp_two_hold_ctrl", 64'(out_ctrl), 64'h0A1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_ctrl_b", 64'(out_ctrl), 64'h0B1);
    chk("bp_data_b", out_data, {32'hB2, 32'hB1});
    chk("bp_occ_after_a", 64'(occupancy), 64'd1);
    chk("bp_in_ready1", 64'(in_ready), 64'd1);
    @(negedge clk);
    chk("bp_drained_valid", 64'(out_valid), 64'd0);
    chk("bp_drained_ctrl", 64'(out_ctrl), 64'd0);

    out_ready = 1'b0;
    send(11'h0C1, {32'hC2, 32'hC1});
    @(negedge clk);
    send(11'h0C3, {32'hC4, 32'hC3});
    @(negedge clk);
    chk("fl_pre_occ", 64'(occupancy), 64'd2);
    flush = 1'b1;
    send(11'h0C5, {32'hC6, 32'hC5});
    @(negedge clk);
    chk("fl_occ", 64'(occupancy), 64'd0);
    chk("fl_ctrl", 64'(out_ctrl), 64'd0);
    chk("fl_data", out_data, 64'd0);
    chk("fl_in_ready", 64'(in_ready), 64'd1);
    chk("fl_valid", 64'(out_valid), 64'd0);
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("fl_stays_empty", 64'(out_valid), 64'd0);
    out_ready = 1'b0;
    send(11'h0D1, {32'hD2, 32'hD1});
    @(negedge clk);
    flush = 1'b1;
    send(11'h0D3, {32'hD4, 32'hD3});
    @(negedge clk);
    chk("fl_one_accept_discard_occ", 64'(occupancy), 64'd0);
    chk("fl_one_accept_discard_ctrl", 64'(out_ctrl), 64'd0);
    flush = 1'b0;
    in_valid = 1'b0;

    send(11'h0E1, {32'hE2, 32'hE1});
    @(negedge clk);
    send(11'h0E3, {32'hE4, 32'hE3});
    @(negedge clk);
    chk("ar_pre_occ", 64'(occupancy), 64'd2);
    in_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("ar_occ", 64'(occupancy), 64'd0);
    chk("ar_valid", 64'(out_valid), 64'd0);
    chk("ar_ctrl", 64'(out_ctrl), 64'd0);
    chk("ar_data", out_data, 64'd0);
    chk("ar_in_ready", 64'(in_ready), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    send(11'h0E5, {32'hE6, 32'hE5});
    @(negedge clk);
    chk("ar_c_ctrl", 64'(out_ctrl), 64'h0E5);
    chk("ar_c_data", out_data, {32'hE6, 32'hE5});
    chk("ar_c_valid", 64'(out_valid), 64'd1);
    in_valid = 1'b0;
    @(negedge clk);

    p_out_ready = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      p_in_valid = 1'b1;
      p_in_ctrl = 5'(k);
      p_in_data = {8'(k + 2), 8'(k + 1), 8'(k)};
      @(negedge clk);
      chk("p_stream_ctrl", 64'(p_out_ctrl), 64'(k));
      chk("p_stream_data", 64'(p_out_data), 64'({8'(k + 2), 8'(k + 1), 8'(k)}));
      chk("p_stream_occ", 64'(p_occupancy), 64'd1);
      chk("p_stream_in_ready", 64'(p_in_ready), 64'd1);
    end
    p_in_ctrl = 5'h1F;
    p_in_data = 24'hC3B2A1;
    @(negedge clk);
    chk("p_slice_op0", 64'(p_out_data[7:0]), 64'hA1);
    chk("p_slice_op1", 64'(p_out_data[15:8]), 64'hB2);
    chk("p_slice_op2", 64'(p_out_data[23:16]), 64'hC3);
    chk("p_slice_ctrl", 64'(p_out_ctrl), 64'h1F);
    p_in_valid = 1'b0;
    @(negedge clk);
    chk("p_bubble_ctrl", 64'(p_out_ctrl), 64'd0);
    chk("p_bubble_data_hold", 64'(p_out_data), 64'hC3B2A1);
    p_out_ready = 1'b0;
    p_in_valid = 1'b1;
    p_in_ctrl = 5'h0A;
    p_in_data = 24'h0A0B0C;
    @(negedge clk);
    p_in_ctrl = 5'h15;
    p_in_data = 24'h151617;
    @(negedge clk);
    chk("p_bp_occ2", 64'(p_occupancy), 64'd2);
    chk("p_bp_in_ready0", 64'(p_in_ready), 64'd0);
    chk("p_bp_ctrl_a", 64'(p_out_ctrl), 64'h0A);
    p_in_valid = 1'b0;
    p_out_ready = 1'b1;
    @(negedge clk);
    chk("p_bp_ctrl_b", 64'(p_out_ctrl), 64'h15);
    chk("p_bp_data_b", 64'(p_out_data), 64'h151617);
    @(negedge clk);
    chk("p_bp_drained", 64'(p_out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register for the pipelined core. It replaces the fixed-width, always-advancing stage latches with a block that has valid/ready handshaking, a synchronous flush for branch/hazard squash, and a two-entry skid buffer so that backpressure never drops or duplicates an instruction. It is instantiated between ID/EX, EX/MEM and MEM/WB, each with its own control and data widths.

## Interface

Parameters:
- CTRL_W, default 11, width of the control bundle (PCSrc, MemtoReg, MemWrite, ALUControl[2:0], ALUSrc, RegWrite, FlagWrite[1:0], Branch).
- DATA_W, default 32, width of one data operand.
- NUM_OPS, default 2, number of data operands carried; operand k occupies bits [k*DATA_W +: DATA_W].

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high.
- flush  input  1  synchronous squash of all held entries.
- in_valid  input  1  upstream presents an instruction.
- in_ready  output  1  stage can accept an instruction; registered.
- in_ctrl  input  CTRL_W  upstream control bundle.
- in_data  input  NUM_OPS*DATA_W  upstream operands.
- out_valid  output  1  out_ctrl and out_data hold a live instruction.
- out_ready  input  1  downstream accepts this cycle.
- out_ctrl  output  CTRL_W  registered control bundle; all-zero when out_valid=0.
- out_data  output  NUM_OPS*DATA_W  registered operands.
- occupancy  output  2  number of held entries: 0, 1 or 2.

## Operation

- Storage: main entry (drives out_*) and skid entry. State: EMPTY (0 entries), ONE (main valid), TWO (main and skid valid). occupancy encodes the state directly.
- Accept: in_valid && in_ready. Deliver: out_valid && out_ready.
- in_ready = (state != TWO). out_valid = (state != EMPTY). Both are decoded from registered state only, with no combinational path from in_valid or out_ready.
- Transitions, with flush=0:
  - EMPTY, accept: main <= in. Next state ONE.
  - ONE, accept without deliver: skid <= in. Next state TWO.
  - ONE, deliver without accept: main ctrl <= 0. Next state EMPTY.
  - ONE, accept and deliver: main <= in. Next state ONE.
  - ONE, neither: hold.
  - TWO, deliver: main <= skid. Next state ONE.
  - TWO, no deliver: hold. No accept is possible in TWO.
- Bubble rule: main ctrl is all-zero whenever the stage is EMPTY, so that RegWrite, MemWrite and Branch can never fire from a bubble. out_data is not cleared on drain; it holds its last value.
- flush=1 has highest priority:
  - Next state EMPTY.
  - main ctrl, skid ctrl, main data and skid data are all cleared to zero.
  - An accept handshake in the same cycle is discarded, even though in_ready was 1.
  - A deliver in the same cycle still completes, since downstream has already sampled out_*.
- Ordering is strictly FIFO: the skid entry is always older than any new input.

## Timing

- Reset (asynchronous) values:
  - state EMPTY, occupancy 0.
  - in_ready 1, out_valid 0.
  - out_ctrl 0, out_data 0, skid contents 0.
- Latency: in the EMPTY state, or ONE with a same-cycle deliver, an instruction accepted at edge N is on out_* with out_valid=1 after edge N.
- Throughput: 1 instruction per cycle when out_ready is held at 1.
- in_ready drops in the cycle after the second entry is captured. It rises in the cycle after the first deliver from TWO.
- Reset asserted mid-operation clears everything immediately. The first accept is possible at the first rising edge after reset deasserts.
- Flush takes effect at the edge where it is sampled high. in_ready=1 and out_valid=0 in the following cycle.

## Test plan

- Streaming: out_ready=1, send ctrl 0x001..0x008 with data pairs (k, 100+k) back-to-back. Required: out_* in the same order, one cycle later, occupancy never exceeds 1, in_ready stays 1.
- Backpressure: out_ready=0 and send A then B. Required: occupancy 2 and in_ready=0 after the second edge, out_ctrl=A held. Then raise out_ready. Required: A delivered, then B, with no loss or duplicate.
- Bubble: after draining to EMPTY with out_ready=1, out_ctrl must be 0x000 and out_valid=0 while out_data holds its last value.
- Flush in TWO plus simultaneous accept attempt. Required next cycle: occupancy 0, out_ctrl 0, out_data 0, in_ready=1. The flushed and offered instructions never appear on the output.
- Async reset asserted between clock edges while TWO. Required: outputs cleared before the next rising edge, and after release a new instruction C emerges with 1-cycle latency.
- Parameter sweep: CTRL_W=5, DATA_W=8, NUM_OPS=3. Repeat the streaming and backpressure scenarios and check operand slicing for data 0xA1, 0xB2, 0xC3.
